// File: rtl/wb_ram_slave_pkg.sv
// Shared widths and FSM state encoding for the Wishbone RAM slave.
package wb_ram_slave_pkg;

   localparam int unsigned WB_DW = 32;
   localparam int unsigned WB_SW = 4;
   localparam int unsigned WB_AW = 32;
   localparam int unsigned CNT_W = 4;

   typedef enum logic [2:0] {
      S_IDLE,
      S_WAIT,
      S_ACK,
      S_ERR,
      S_RTY
   } state_e;

endpackage

// File: rtl/wb_ram_slave_mem.sv
// Single-port word RAM with byte enables and a registered read port.
module wb_ram_slave_mem
   import wb_ram_slave_pkg::*;
#(
   parameter int unsigned AW = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic [AW-1:0]    addr_i,
   input  logic             we_i,
   input  logic [WB_SW-1:0] be_i,
   input  logic [WB_DW-1:0] wdata_i,
   output logic [WB_DW-1:0] rdata_o
);

   localparam int unsigned DEPTH = 1 << AW;

   logic [WB_DW-1:0] mem_q [DEPTH];
   logic [WB_DW-1:0] rdata_q;

   // Storage is deliberately not reset.
   always_ff @(posedge clk_i) begin
      if (we_i) begin
         for (int unsigned b = 0; b < WB_SW; b++) begin
            if (be_i[b]) mem_q[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) rdata_q <= '0;
      else         rdata_q <= mem_q[addr_i];
   end

   assign rdata_o = rdata_q;

endmodule

// File: rtl/wb_ram_slave.sv
// Wishbone RAM slave with wait states, error/retry terminations.
// Optional consecutive-address bursts via macro WB_RAM_SLAVE_CAB_EN.
module wb_ram_slave
   import wb_ram_slave_pkg::*;
#(
   parameter int unsigned AW   = 10,
   parameter int unsigned WAIT = 1,
   parameter int unsigned BASE = 0
) (
   input  logic             wb_clk_i,
   input  logic             wb_rst_i,
   input  logic             wb_cyc_i,
   input  logic             wb_stb_i,
   input  logic             wb_we_i,
   input  logic [WB_SW-1:0] wb_sel_i,
   input  logic [WB_AW-1:0] wb_adr_i,
   input  logic [WB_DW-1:0] wb_dat_i,
`ifdef WB_RAM_SLAVE_CAB_EN
   input  logic             wb_cab_i,
`endif
   input  logic             hold_i,
   output logic [WB_DW-1:0] wb_dat_o,
   output logic             wb_ack_o,
   output logic             wb_err_o,
   output logic             wb_rty_o
);

   localparam int unsigned      TAG_W     = WB_AW - AW - 2;
   localparam logic [CNT_W-1:0] WAIT_LOAD = (WAIT == 0) ? '0 : CNT_W'(WAIT - 1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             ack_q, err_q, rty_q;
   logic             beat_we_q;
   logic [AW-1:0]    beat_adr_q;
   logic [WB_DW-1:0] beat_dat_q;
   logic [WB_SW-1:0] beat_sel_q;

   logic             req_c, bad_c, mem_we_c;
   logic [AW-1:0]    mem_adr_c;
   logic [WB_DW-1:0] rdata;

   assign req_c = wb_cyc_i & wb_stb_i;
   assign bad_c = (wb_adr_i[WB_AW-1:AW+2] != TAG_W'(BASE)) || (wb_adr_i[1:0] != 2'b00);

   // Next-state decode; ERR, RTY and single ACK always fall back to IDLE.
   always_comb begin
      state_d = S_IDLE;
      cnt_d   = '0;
      case (state_q)
         S_IDLE: begin
            if (req_c) begin
               if (bad_c)          state_d = S_ERR;
               else if (hold_i)    state_d = S_RTY;
               else if (WAIT == 0) state_d = S_ACK;
               else begin
                  state_d = S_WAIT;
                  cnt_d   = WAIT_LOAD;
               end
            end
         end
         S_WAIT: begin
            if (req_c) begin
               if (cnt_q == '0) state_d = S_ACK;
               else begin
                  state_d = S_WAIT;
                  cnt_d   = cnt_q - CNT_W'(1);
               end
            end
         end
`ifdef WB_RAM_SLAVE_CAB_EN
         // Burst beats are pipelined: the next beat is presented during the current ack.
         S_ACK: begin
            if (req_c && wb_cab_i) state_d = bad_c ? S_ERR : S_ACK;
         end
`endif
         default: ;
      endcase
   end

   always_ff @(posedge wb_clk_i or negedge wb_rst_i) begin
      if (!wb_rst_i) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         ack_q      <= 1'b0;
         err_q      <= 1'b0;
         rty_q      <= 1'b0;
         beat_we_q  <= 1'b0;
         beat_adr_q <= '0;
         beat_dat_q <= '0;
         beat_sel_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         ack_q   <= (state_d == S_ACK);
         err_q   <= (state_d == S_ERR);
         rty_q   <= (state_d == S_RTY);
         if (state_d == S_ACK) begin
            beat_we_q  <= wb_we_i;
            beat_adr_q <= wb_adr_i[AW+1:2];
            beat_dat_q <= wb_dat_i;
            beat_sel_q <= wb_sel_i;
         end
      end
   end

   // Write lands on the edge closing the ack cycle; otherwise read the live address one cycle ahead.
   assign mem_we_c  = ack_q & beat_we_q;
   assign mem_adr_c = mem_we_c ? beat_adr_q : wb_adr_i[AW+1:2];

   wb_ram_slave_mem #(
      .AW (AW)
   ) u_mem (
      .clk_i   (wb_clk_i),
      .rst_ni  (wb_rst_i),
      .addr_i  (mem_adr_c),
      .we_i    (mem_we_c),
      .be_i    (beat_sel_q),
      .wdata_i (beat_dat_q),
      .rdata_o (rdata)
   );

   assign wb_dat_o = (ack_q && !beat_we_q) ? rdata : '0;
   assign wb_ack_o = ack_q;
   assign wb_err_o = err_q;
   assign wb_rty_o = rty_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Scoreboard bench for wb_ram_slave: WAIT=1 and WAIT=3 instances share one bus.
module tb_wb_ram_slave;

   localparam int K_ACK = 0;
   localparam int K_ERR = 1;
   localparam int K_RTY = 2;

   typedef struct {
      int          kind;
      logic [31:0] data;
      bit          chk;
      longint      cyc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        cyc1 = 1'b0, cyc3 = 1'b0, stb = 1'b0, we = 1'b0, hold = 1'b0;
   logic [3:0]  sel = 4'h0;
   logic [31:0] adr = '0, dat = '0;
`ifdef WB_RAM_SLAVE_CAB_EN
   logic        cab = 1'b0;
`endif
   logic [31:0] dat1, dat3;
   logic        ack1, err1, rty1, ack3, err3, rty3;

   exp_t   q1[$];
   exp_t   q3[$];
   longint cyc_cnt = 0;
   int     n_pass = 0;
   int     n_total = 0;

   always #5 clk = ~clk;
   always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

   wb_ram_slave #(.AW(10), .WAIT(1), .BASE(0)) u_dut1 (
      .wb_clk_i (clk),  .wb_rst_i (rst_n), .wb_cyc_i (cyc1), .wb_stb_i (stb),
      .wb_we_i  (we),   .wb_sel_i (sel),   .wb_adr_i (adr),  .wb_dat_i (dat),
`ifdef WB_RAM_SLAVE_CAB_EN
      .wb_cab_i (cab),
`endif
      .hold_i   (hold), .wb_dat_o (dat1),  .wb_ack_o (ack1), .wb_err_o (err1),
      .wb_rty_o (rty1)
   );

   wb_ram_slave #(.AW(10), .WAIT(3), .BASE(0)) u_dut3 (
      .wb_clk_i (clk),  .wb_rst_i (rst_n), .wb_cyc_i (cyc3), .wb_stb_i (stb),
      .wb_we_i  (we),   .wb_sel_i (sel),   .wb_adr_i (adr),  .wb_dat_i (dat),
`ifdef WB_RAM_SLAVE_CAB_EN
      .wb_cab_i (1'b0),
`endif
      .hold_i   (hold), .wb_dat_o (dat3),  .wb_ack_o (ack3), .wb_err_o (err3),
      .wb_rty_o (rty3)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
   endtask

   // Monitor: pops one expectation per termination seen on a DUT.
   task automatic mon(input int d, input logic a, input logic e, input logic r, input logic [31:0] dq);
      exp_t ex;
      bit   have;
      int   kind;
      check($sformatf("one_term_d%0d", d), 64'($countones({a, e, r}) <= 1), 64'd1);
      if (!a) check($sformatf("dat_zero_d%0d", d), 64'(dq), 64'd0);
      if (a || e || r) begin
         have = 1'b0;
         if (d == 0) begin
            if (q1.size() != 0) begin ex = q1.pop_front(); have = 1'b1; end
         end else begin
            if (q3.size() != 0) begin ex = q3.pop_front(); have = 1'b1; end
         end
         if (!have) check($sformatf("unexpected_term_d%0d", d), 64'({a, e, r}), 64'd0);
         else begin
            kind = a ? K_ACK : (e ? K_ERR : K_RTY);
            check($sformatf("kind_d%0d", d), 64'(kind), 64'(ex.kind));
            check($sformatf("cycle_d%0d", d), 64'(cyc_cnt), 64'(ex.cyc));
            if (ex.chk) check($sformatf("rdata_d%0d", d), 64'(dq), 64'(ex.data));
         end
      end
   endtask

   always @(negedge clk) begin
      if (rst_n) begin
         mon(0, ack1, err1, rty1, dat1);
         mon(1, ack3, err3, rty3, dat3);
      end
   end

   task automatic wait_term(input int d, output bit seen);
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (d == 0 ? (ack1 | err1 | rty1) : (ack3 | err3 | rty3)) begin
            seen = 1'b1;
            break;
         end
      end
   endtask

   task automatic drop_bus();
      cyc1 = 1'b0; cyc3 = 1'b0; stb = 1'b0; we = 1'b0; hold = 1'b0;
`ifdef WB_RAM_SLAVE_CAB_EN
      cab = 1'b0;
`endif
   endtask

   task automatic do_single(input int d, input bit w, input logic [31:0] a, input logic [31:0] wd,
                            input logic [3:0] s, input bit h, input int kind, input logic [31:0] rd);
      exp_t e;
      int   lat;
      bit   seen;
      @(posedge clk); #1;
      if (d == 0) cyc1 = 1'b1; else cyc3 = 1'b1;
      stb = 1'b1; we = w; adr = a; dat = wd; sel = s; hold = h;
      lat = (kind == K_ACK) ? 1 + (d == 0 ? 1 : 3) : 1;
      e = '{kind: kind, data: rd, chk: (kind == K_ACK) && !w, cyc: cyc_cnt + longint'(lat)};
      if (d == 0) q1.push_back(e); else q3.push_back(e);
      wait_term(d, seen);
      check("term_seen", 64'(seen), 64'd1);
      @(posedge clk); #1;
      drop_bus();
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, "_ack1"}, 64'(ack1), 64'd0);
      check({tag, "_err1"}, 64'(err1), 64'd0);
      check({tag, "_rty1"}, 64'(rty1), 64'd0);
      check({tag, "_dat1"}, 64'(dat1), 64'd0);
      check({tag, "_ack3"}, 64'(ack3), 64'd0);
      check({tag, "_dat3"}, 64'(dat3), 64'd0);
   endtask

`ifdef WB_RAM_SLAVE_CAB_EN
   task automatic do_burst(input bit w);
      exp_t   e;
      bit     seen;
      longint n;
      @(posedge clk); #1;
      cyc1 = 1'b1; stb = 1'b1; cab = 1'b1; we = w; sel = 4'hF; adr = 32'h0; dat = 32'd1;
      n = cyc_cnt;
      for (int k = 0; k < 4; k++) begin
         e = '{kind: K_ACK, data: 32'(k + 1), chk: !w, cyc: n + 2 + longint'(k)};
         q1.push_back(e);
      end
      wait_term(0, seen);
      check("burst_first", 64'(seen), 64'd1);
      adr = 32'h4; dat = 32'd2;
      for (int k = 2; k < 4; k++) begin
         @(posedge clk); #1;
         adr = 32'(4 * k); dat = 32'(k + 1);
      end
      @(posedge clk); #1;
      drop_bus();
   endtask
`endif

   initial begin
      bit          seen;
      exp_t        e;
      repeat (3) @(posedge clk);
      #1;
      check_idle_outputs("reset");
      rst_n = 1'b1;

      // Basic write/read and partial-lane write.
      do_single(0, 1, 32'h10, 32'hDEADBEEF, 4'hF, 0, K_ACK, 32'h0);
      do_single(0, 0, 32'h10, 32'h0,        4'hF, 0, K_ACK, 32'hDEADBEEF);
      do_single(0, 1, 32'h10, 32'h000000AA, 4'h1, 0, K_ACK, 32'h0);
      do_single(0, 0, 32'h10, 32'h0,        4'h3, 0, K_ACK, 32'hDEADBEAA);

      // Errors: misaligned, out of window, error beats retry, no aliasing.
      do_single(0, 0, 32'h2,    32'h0, 4'hF, 0, K_ERR, 32'h0);
      do_single(0, 0, 32'h1010, 32'h0, 4'hF, 0, K_ERR, 32'h0);
      do_single(0, 0, 32'h2,    32'h0, 4'hF, 1, K_ERR, 32'h0);
      do_single(0, 1, 32'h1010, 32'hFFFFFFFF, 4'hF, 0, K_ERR, 32'h0);
      do_single(0, 0, 32'h10,   32'h0, 4'hF, 0, K_ACK, 32'hDEADBEAA);

      // Retry then success.
      do_single(0, 0, 32'h10, 32'h0, 4'hF, 1, K_RTY, 32'h0);
      do_single(0, 0, 32'h10, 32'h0, 4'hF, 0, K_ACK, 32'hDEADBEAA);

      // Top word of the window with a sparse lane mask.
      do_single(0, 1, 32'hFFC, 32'hCAFEF00D, 4'hF, 0, K_ACK, 32'h0);
      do_single(0, 1, 32'hFFC, 32'h11223344, 4'hA, 0, K_ACK, 32'h0);
      do_single(0, 0, 32'hFFC, 32'h0,        4'hF, 0, K_ACK, 32'h11FE330D);

      // WAIT=3 instance: write, aborted write, read back old value.
      do_single(1, 1, 32'h20, 32'h12345678, 4'hF, 0, K_ACK, 32'h0);
      @(posedge clk); #1;
      cyc3 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h20; dat = 32'h55; sel = 4'hF;
      @(posedge clk);
      @(posedge clk); #1;
      drop_bus();
      repeat (6) @(posedge clk);
      do_single(1, 0, 32'h20, 32'h0, 4'hF, 0, K_ACK, 32'h12345678);

      // Reset during the ack cycle of a write: no write, no late termination.
      @(posedge clk); #1;
      cyc1 = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; dat = 32'h0; sel = 4'hF;
      e = '{kind: K_ACK, data: 32'h0, chk: 1'b0, cyc: cyc_cnt + 2};
      q1.push_back(e);
      wait_term(0, seen);
      check("rst_ack_seen", 64'(seen), 64'd1);
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("mid_rst");
      drop_bus();
      @(posedge clk); #1;
      rst_n = 1'b1;
      repeat (4) @(posedge clk);
      do_single(0, 0, 32'h10, 32'h0, 4'hF, 0, K_ACK, 32'hDEADBEAA);

`ifdef WB_RAM_SLAVE_CAB_EN
      do_burst(1'b1);
      do_burst(1'b0);

      // Misaligned second beat ends the burst with one error.
      @(posedge clk); #1;
      cyc1 = 1'b1; stb = 1'b1; cab = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
      e = '{kind: K_ACK, data: 32'd1, chk: 1'b1, cyc: cyc_cnt + 2};
      q1.push_back(e);
      e = '{kind: K_ERR, data: 32'h0, chk: 1'b0, cyc: cyc_cnt + 3};
      q1.push_back(e);
      wait_term(0, seen);
      check("burst_err_first", 64'(seen), 64'd1);
      adr = 32'h2;
      @(posedge clk); #1;
      drop_bus();
      repeat (4) @(posedge clk);

      // Reset pulsed mid-burst.
      @(posedge clk); #1;
      cyc1 = 1'b1; stb = 1'b1; cab = 1'b1; we = 1'b0; sel = 4'hF; adr = 32'h0;
      e = '{kind: K_ACK, data: 32'd1, chk: 1'b1, cyc: cyc_cnt + 2};
      q1.push_back(e);
      wait_term(0, seen);
      check("burst_rst_first", 64'(seen), 64'd1);
      adr = 32'h4;
      #2 rst_n = 1'b0;
      #1 check_idle_outputs("burst_rst");
      q1.delete();
      repeat (2) @(posedge clk);
      #1 drop_bus();
      @(negedge clk) rst_n = 1'b1;
      repeat (4) @(posedge clk);
      do_single(0, 0, 32'h4, 32'h0, 4'hF, 0, K_ACK, 32'd2);
      do_single(0, 0, 32'hC, 32'h0, 4'hF, 0, K_ACK, 32'd4);
`endif

      repeat (4) @(posedge clk);
      check("q1_drained", 64'(q1.size()), 64'd0);
      check("q3_drained", 64'(q3.size()), 64'd0);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d/%0d checks passed", n_pass, n_total);
      $fatal(1);
   end

endmodule
